// File: rtl/spi_rx_packer_pkg.sv
// Shared definitions for the SPI receive packer: FSM state encoding,
// byte-count width and beat-size encodings shared with the shift core.
package spi_rx_packer_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Buffer occupancy counter width (0..8 bytes)
  localparam int CNT_W = 4;

  // in_bytes encodings: valid bytes in beat minus one
  localparam logic [1:0] BEAT_8  = 2'd0;
  localparam logic [1:0] BEAT_16 = 2'd1;
  localparam logic [1:0] BEAT_24 = 2'd2;
  localparam logic [1:0] BEAT_32 = 2'd3;

  // Byte j (0 = first received) of an LSB-aligned beat holding n+1 bytes;
  // the most significant valid byte arrives first.
  function automatic logic [7:0] beat_byte(input logic [31:0] d,
                                           input logic [1:0]  n,
                                           input logic [1:0]  j);
    logic [1:0] sel;
    sel = n - j;
    return d[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_rx_packer_idle_timer.sv
// Idle timer for the RX packer: counts while run_i is high, clears otherwise,
// and pulses expire_o on the cycle the count reaches TIMEOUT_CYCLES-1.
module spi_rx_idle_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Next count: restart on expiry or whenever the idle condition drops
  always_comb begin
    cnt_d = '0;
    if (run_i && !expire_o) cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset/clear
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) cnt_q <= '0;
    else                   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_rx_packer.sv
// SPI receive packer: gathers 8..32-bit beats from the shift core into
// 32-bit words for the RX FIFO, with flush of partial words.
// Optional feature macro: SPI_RX_PACKER_TIMEOUT_EN (idle auto-flush timer).
module spi_rx_packer
  import spi_rx_packer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        rev_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [1:0]  in_bytes_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [2:0]  out_bytes_o
);

  logic [7:0][7:0]  buf_q, buf_d, buf_pop;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_mid, pop_n, push_n;
  state_e           state_q, state_d;
  logic             in_hs, out_hs, tmo_expire;

  // Handshake-facing outputs depend only on registered state
  assign in_ready_o  = (state_q == ST_FILL) && (cnt_q <= 4'd4);
  assign out_valid_o = (state_q == ST_FILL) ? (cnt_q >= 4'd4) : (cnt_q != '0);
  assign out_bytes_o = ((state_q == ST_FILL) || (cnt_q >= 4'd4)) ? 3'd4 : cnt_q[2:0];

  assign in_hs  = in_valid_i && in_ready_o;
  assign out_hs = out_valid_o && out_ready_i;
  assign pop_n  = out_hs ? {1'b0, out_bytes_o} : '0;
  assign push_n = in_hs ? ({2'b00, in_bytes_i} + 4'd1) : '0;

  // Head bytes onto output lanes; lanes past the occupancy read as zero
  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (4'(k) < cnt_q)
        out_data_o[8*(rev_i ? (3 - k) : k) +: 8] = buf_q[k];
    end
  end

  // Buffer next state: pop from the head first, then append behind the rest
  always_comb begin
    buf_pop = '0;
    buf_d   = '0;
    cnt_mid = cnt_q - pop_n;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) + pop_n) < 4'd8) buf_pop[i] = buf_q[3'(4'(i) + pop_n)];
    end
    for (int i = 0; i < 8; i++) begin
      buf_d[i] = buf_pop[i];
      if (in_hs && (4'(i) >= cnt_mid) && ((4'(i) - cnt_mid) <= {2'b00, in_bytes_i}))
        buf_d[i] = beat_byte(in_data_i, in_bytes_i, 2'(4'(i) - cnt_mid));
    end
    cnt_d = cnt_mid + push_n;
  end

`ifdef SPI_RX_PACKER_TIMEOUT_EN
  logic tmo_run;
  assign tmo_run = (state_q == ST_FILL) && (cnt_q != '0) && (cnt_q <= 4'd3) && !in_hs;

  spi_rx_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (clr_i),
    .run_i    (tmo_run),
    .expire_o (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // FSM next state: enter DRAIN to emit a partial word, return once empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if ((flush_i || tmo_expire) && (cnt_q != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == '0) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // State registers; reset and clear both discard all buffered bytes
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_spi_rx_packer.sv
// Directed self-checking bench for spi_rx_packer.
module tb_spi_rx_packer;

  logic        clk = 1'b0;
  logic        rst_n, clr, rev, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_bytes;
  logic [2:0]  out_bytes;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  spi_rx_packer #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .clr_i       (clr),
    .rev_i       (rev),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_bytes_i  (in_bytes),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_bytes_o (out_bytes)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] nb);
    in_valid = 1'b1; in_data = d; in_bytes = nb;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; rev = 1'b0; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; in_data = '0; in_bytes = '0;
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_out_bytes", 32'(out_bytes), 32'd4);
    rst_n = 1'b1;
    tick();

    // Four 8-bit beats pack into one word, both byte orders
    beat(32'h11, 2'd0); beat(32'h22, 2'd0); beat(32'h33, 2'd0);
    chk("b8_not_yet_valid", 32'(out_valid), 32'd0);
    beat(32'h44, 2'd0);
    chk("b8_valid",     32'(out_valid), 32'd1);
    chk("b8_data_rev0", out_data,       32'h44332211);
    chk("b8_bytes",     32'(out_bytes), 32'd4);
    rev = 1'b1; #1;
    chk("b8_data_rev1", out_data,       32'h11223344);
    rev = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("b8_popped", 32'(out_valid), 32'd0);

    // 24-bit + 16-bit beats then flush
    beat(32'h00112233, 2'd2);
    chk("m_in_ready_cnt3", 32'(in_ready), 32'd1);
    beat(32'h00004455, 2'd1);
    chk("m_in_ready_cnt5", 32'(in_ready), 32'd0);
    chk("m_word0",         out_data,      32'h44332211);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("m_drain_ready", 32'(in_ready),  32'd0);
    chk("m_drain_bytes", 32'(out_bytes), 32'd4);
    out_ready = 1'b1; tick();
    chk("m_word1",       out_data,       32'h00000055);
    chk("m_word1_bytes", 32'(out_bytes), 32'd1);
    chk("m_word1_ready", 32'(in_ready),  32'd0);
    tick(); out_ready = 1'b0;
    chk("m_empty_valid", 32'(out_valid), 32'd0);
    chk("m_empty_ready", 32'(in_ready),  32'd0);
    tick();
    chk("m_back_fill", 32'(in_ready), 32'd1);

    // Backpressure: fill to 8 bytes, hold a third beat, then drain
    beat(32'h01020304, 2'd3);
    chk("bp_ready_cnt4", 32'(in_ready), 32'd1);
    beat(32'h05060708, 2'd3);
    chk("bp_ready_cnt8", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 32'h090A0B0C; in_bytes = 2'd3;
    chk("bp_word0", out_data, 32'h04030201);
    tick();
    chk("bp_stall_data",  out_data,       32'h04030201);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; tick();
    chk("bp_word1",  out_data,      32'h08070605);
    chk("bp_ready4", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("bp_word2", out_data, 32'h0C0B0A09);
    chk("bp_word2_valid", 32'(out_valid), 32'd1);
    tick(); out_ready = 1'b0;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // clr_i in DRAIN with three bytes pending
    beat(32'h00AABBCC, 2'd2);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    chk("clr_pre_bytes", 32'(out_bytes), 32'd3);
    chk("clr_pre_data",  out_data,       32'h00CCBBAA);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_ready", 32'(in_ready),  32'd1);
    chk("clr_data",  out_data,       32'h0);
    chk("clr_bytes", 32'(out_bytes), 32'd4);

    // Reset in DRAIN with three bytes pending
    beat(32'h00DDEEFF, 2'd2);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("rst2_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_ready", 32'(in_ready),  32'd1);
    chk("rst2_data",  out_data,       32'h0);

    // Idle timeout on a single byte
    beat(32'h000000A5, 2'd0);
    for (int i = 0; i < 63; i++) tick();
    chk("tmo_before", 32'(out_valid), 32'd0);
    tick();
`ifdef SPI_RX_PACKER_TIMEOUT_EN
    chk("tmo_valid", 32'(out_valid), 32'd1);
    chk("tmo_data",  out_data,       32'h000000A5);
    chk("tmo_bytes", 32'(out_bytes), 32'd1);
    chk("tmo_ready", 32'(in_ready),  32'd0);
`else
    for (int i = 0; i < 16; i++) tick();
    chk("notmo_valid", 32'(out_valid), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("notmo_flush_data", out_data, 32'h000000A5);
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("tmo_drained", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
